// File: rtl/fence_seq_ctrl.sv
// Fence sequencer: drains stores, optionally flushes the D$, invalidates I$/TLB, then flushes the pipeline.
// Define FENCE_SEQ_TIMEOUT_EN to enable the DRAIN/DFLUSH watchdog; without it timeout_o is tied low.
module fence_seq_ctrl #(
  parameter int unsigned DCACHE_FLUSH_ON_FENCE = 0,
  parameter int unsigned XLEN                  = 64,
  parameter int unsigned ASID_W                = 16,
  parameter int unsigned TIMEOUT_CYCLES        = 1023
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_type_i,
  input  logic [XLEN-1:0]   vaddr_i,
  input  logic [ASID_W-1:0] asid_i,
  input  logic              no_st_pending_i,
  output logic              dcache_flush_o,
  input  logic              dcache_flush_ack_i,
  output logic              icache_flush_o,
  output logic              tlb_flush_o,
  output logic [XLEN-1:0]   tlb_vaddr_o,
  output logic [ASID_W-1:0] tlb_asid_o,
  output logic              halt_frontend_o,
  output logic              flush_pipeline_o,
  output logic              done_o,
  output logic              timeout_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_DFLUSH = 3'd2;
  localparam logic [2:0] S_INVAL  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0] state_q, state_d;
  logic [1:0] type_q;
  logic       accept;
  logic       waiting;
  logic       normal_exit;
  logic       needs_dflush;
  logic       to_fire;

  assign accept       = (state_q == S_IDLE) && req_valid_i;
  assign waiting      = (state_q == S_DRAIN) || (state_q == S_DFLUSH);
  assign normal_exit  = ((state_q == S_DRAIN) && no_st_pending_i) ||
                        ((state_q == S_DFLUSH) && dcache_flush_ack_i);
  // Only plain FENCE (00) and FENCE.I (01) take the D$ flush; SFENCE variants never do.
  assign needs_dflush = (DCACHE_FLUSH_ON_FENCE != 0) && !type_q[1];

`ifdef FENCE_SEQ_TIMEOUT_EN
  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_q;

  // The count spans DRAIN and DFLUSH together and pins at the limit, so a flush
  // entered with the budget already spent times out on its first cycle.
  assign cnt_inc = (cnt_q == CNT_LIM) ? CNT_LIM : cnt_q + CNT_W'(1);
  assign to_fire = waiting && (cnt_inc == CNT_LIM) && !normal_exit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (waiting) cnt_q <= cnt_inc;
      if (to_fire) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign to_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid_i) state_d = S_DRAIN;
      S_DRAIN: begin
        if (no_st_pending_i) state_d = needs_dflush ? S_DFLUSH : S_INVAL;
        else if (to_fire)    state_d = S_INVAL;
      end
      S_DFLUSH: if (dcache_flush_ack_i || to_fire) state_d = S_INVAL;
      S_INVAL:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      type_q      <= '0;
      tlb_vaddr_o <= '0;
      tlb_asid_o  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        type_q      <= req_type_i;
        tlb_vaddr_o <= vaddr_i;
        tlb_asid_o  <= asid_i;
      end
    end
  end

  assign req_ready_o      = (state_q == S_IDLE);
  assign halt_frontend_o  = (state_q != S_IDLE);
  assign dcache_flush_o   = (state_q == S_DFLUSH);
  assign icache_flush_o   = (state_q == S_INVAL) && type_q[0];
  assign tlb_flush_o      = (state_q == S_INVAL) && type_q[1];
  assign flush_pipeline_o = (state_q == S_DONE);
  assign done_o           = (state_q == S_DONE);

endmodule
